imem_loader: RTL

- Write-side counterpart of the instruction fetch stage. Streams a program from a byte source (UART receiver) into the instruction ROM/RAM. The fetch stage reads that memory by a 10-bit PC.
- Assembles bytes into 32-bit instruction words and writes them at consecutive word addresses starting at 0.
- Holds the CPU core stalled while a load is in progress.
- Sits between the serial receiver and the instruction memory write port. It is the only writer of that memory.

---
 rtl/imem_loader_pkg.sv | 28 ++
 rtl/imem_loader_if.sv | 35 +++
 rtl/imem_loader_timeout.sv | 34 +++
 rtl/imem_loader.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg: shared types and constants for the instruction-memory loader.
//   state_e        loader FSM states
//   BYTES_PER_WORD bytes assembled into one instruction word
//   IMEM_ADDR_W    default word-address width (matches the fetch PC)
//   MAX_WORDS      largest program the default memory can hold
//   len_ok()       checks a received program length against the memory size
package imem_loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LEN_HI,
    LEN_LO,
    DATA,
    WRITE,
    DONE,
    ERR
  } state_e;

  localparam int unsigned BYTES_PER_WORD = 4;
  localparam int unsigned IMEM_ADDR_W    = 10;
  localparam int unsigned MAX_WORDS      = 2 ** IMEM_ADDR_W;

  // A length is usable when it is non-zero and fits in 2^addr_w words.
  function automatic logic len_ok(input logic [15:0] len, input int unsigned addr_w);
    return (len != 16'd0) && (32'(len) <= (32'd1 << addr_w));
  endfunction

endpackage

// File: rtl/imem_loader_if.sv
// imem_loader_if: byte-source handshake, instruction-memory write port and
// loader status, bundled for the loader and whoever drives/observes it.
//   slave  : the loader (consumes start/rx, drives memory write and status)
//   master : the byte source / system side
//   start, rx_data[7:0], rx_valid          -> loader
//   rx_ready, mem_we, mem_addr, mem_wdata,
//   cpu_hold, done, error, words_loaded    <- loader
interface imem_loader_if #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DATA_W = 32
);
  logic              start;
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              cpu_hold;
  logic              done;
  logic              error;
  logic [ADDR_W:0]   words_loaded;

  modport slave (
    input  start, rx_data, rx_valid,
    output rx_ready, mem_we, mem_addr, mem_wdata,
           cpu_hold, done, error, words_loaded
  );

  modport master (
    output start, rx_data, rx_valid,
    input  rx_ready, mem_we, mem_addr, mem_wdata,
           cpu_hold, done, error, words_loaded
  );
endinterface

// File: rtl/imem_loader_timeout.sv
// imem_loader_timeout: idle counter guarding the byte stream.
//   clk       system clock
//   reset     asynchronous active-low reset
//   i_clear   reload the counter to zero (takes priority over i_enable)
//   i_enable  count one idle cycle
//   o_expired counter has reached TIMEOUT_CYCLES-1
module imem_loader_timeout #(
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic clk,
  input  logic reset,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  localparam int unsigned CNT_W = ($clog2(TIMEOUT_CYCLES) < 1) ? 1 : $clog2(TIMEOUT_CYCLES);

  logic [CNT_W-1:0] r_count;

  assign o_expired = (r_count == CNT_W'(TIMEOUT_CYCLES - 1));

  // Saturates once expired so the flag stays up until the next clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_enable && !o_expired) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/imem_loader.sv
// imem_loader: streams a program from a byte source into instruction memory.
// Receives a 16-bit big-endian word count, then that many 32-bit big-endian
// words, writing them to consecutive word addresses from 0 while holding the
// core stalled. Aborts to an error state on a bad length or an idle timeout.
//   clk    system clock (rising edge)
//   reset  asynchronous active-low reset
//   bus    imem_loader_if.slave: start, rx_* handshake, mem_* write port,
//          cpu_hold, done, error, words_loaded
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int unsigned ADDR_W         = IMEM_ADDR_W,
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic          clk,
  input  logic          reset,
  imem_loader_if.slave  bus
);

  state_e            r_state;
  state_e            w_next;

  logic [7:0]        r_len_hi;
  logic [15:0]       r_len;
  logic [1:0]        r_byte_idx;
  logic [DATA_W-9:0] r_shift;
  logic [DATA_W-1:0] r_wdata;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W:0]   r_words;

  logic              w_rx_ready;
  logic              w_accept;
  logic              w_expired;
  logic              w_restart;
  logic              w_last_byte;
  logic              w_last_word;
  logic [15:0]       w_len_rx;

  assign w_accept    = bus.rx_valid && w_rx_ready;
  assign w_restart   = ((r_state == IDLE) || (r_state == DONE) || (r_state == ERR)) && bus.start;
  assign w_last_byte = (r_byte_idx == 2'(BYTES_PER_WORD - 1));
  assign w_last_word = ((32'(r_words) + 32'd1) == 32'(r_len));
  assign w_len_rx    = {r_len_hi, bus.rx_data};

  // Counting only in the byte-waiting states and clearing everywhere else
  // gives the clear-on-entry behaviour without tracking state transitions.
  imem_loader_timeout #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk       (clk),
    .reset     (reset),
    .i_clear   (w_accept || !w_rx_ready),
    .i_enable  (w_rx_ready),
    .o_expired (w_expired)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE, DONE, ERR: begin
        if (bus.start) w_next = LEN_HI;
      end
      LEN_HI: begin
        if (w_accept)       w_next = LEN_LO;
        else if (w_expired) w_next = ERR;
      end
      LEN_LO: begin
        if (w_accept)       w_next = len_ok(w_len_rx, ADDR_W) ? DATA : ERR;
        else if (w_expired) w_next = ERR;
      end
      DATA: begin
        if (w_accept) begin
          if (w_last_byte) w_next = WRITE;
        end else if (w_expired) begin
          w_next = ERR;
        end
      end
      WRITE: begin
        w_next = w_last_word ? DONE : DATA;
      end
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    w_rx_ready       = (r_state == LEN_HI) || (r_state == LEN_LO) || (r_state == DATA);
    bus.rx_ready     = w_rx_ready;
    bus.mem_we       = (r_state == WRITE);
    bus.cpu_hold     = (r_state == LEN_HI) || (r_state == LEN_LO) || (r_state == DATA) ||
                       (r_state == WRITE)  || (r_state == ERR);
    bus.done         = (r_state == DONE);
    bus.error        = (r_state == ERR);
    bus.mem_addr     = r_addr;
    bus.mem_wdata    = r_wdata;
    bus.words_loaded = r_words;
  end

  // The word is built in a 24-bit shift register and only copied to the
  // write-data register on the 4th byte, so mem_wdata stays stable between
  // writes instead of showing the partially assembled word.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_len_hi   <= '0;
      r_len      <= '0;
      r_byte_idx <= '0;
      r_shift    <= '0;
      r_wdata    <= '0;
      r_addr     <= '0;
      r_words    <= '0;
    end else begin
      if (w_restart) begin
        r_words <= '0;
      end
      case (r_state)
        LEN_HI: begin
          if (w_accept) r_len_hi <= bus.rx_data;
        end
        LEN_LO: begin
          if (w_accept) begin
            r_len      <= w_len_rx;
            r_byte_idx <= '0;
            r_addr     <= '0;
          end
        end
        DATA: begin
          if (w_accept) begin
            r_shift    <= {r_shift[DATA_W-17:0], bus.rx_data};
            r_byte_idx <= r_byte_idx + 2'd1;
            if (w_last_byte) r_wdata <= {r_shift, bus.rx_data};
          end
        end
        WRITE: begin
          r_addr     <= r_addr + ADDR_W'(1);
          r_words    <= r_words + (ADDR_W+1)'(1);
          r_byte_idx <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule
